// File: rtl/ring_counter_n.sv
// ============================================================================
// Module   : ring_counter_n
// Brief    : N-stage phase sequencer, one-hot ring or Johnson mode, with
//            direction, clear, checked parallel load, phase index and wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_counter_n #(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          clr,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  t,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          err
);

  localparam logic [N-1:0]  c_ring_start = N'(1);
  localparam logic [PW-1:0] c_last_ring  = PW'(N-1);
  localparam logic [PW-1:0] c_last_john  = PW'(2*N-1);
  localparam logic [PW:0]   c_two_n      = (PW+1)'(2*N);

  logic [N-1:0]  r_t;
  logic [PW-1:0] r_phase;
  logic          r_wrap;
  logic          r_err;
  logic          r_mode_q;

  logic [N-1:0]  w_t_nxt;
  logic [PW-1:0] w_ph_nxt;
  logic          w_wrap_nxt;
  logic          w_err_nxt;
  logic [N-1:0]  w_start_t;
  logic [N-1:0]  w_inv;
  logic [PW-1:0] w_pop;
  logic [PW-1:0] w_idx;
  logic          w_ring_ok;
  logic          w_john_ok;
  logic          w_load_ok;
  logic [PW-1:0] w_john_ph;
  logic [PW-1:0] w_load_ph;
  logic [PW-1:0] w_last;

  // Population count and highest set bit of the load pattern.
  always_comb begin
    w_pop = '0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (load_val[i]) begin
        w_pop = w_pop + PW'(1);
        w_idx = PW'(i);
      end
    end
  end

  // Johnson-legal patterns are a run of ones anchored at either end.
  assign w_inv     = ~load_val;
  assign w_ring_ok = (w_pop == PW'(1));
  assign w_john_ok = ((load_val & (load_val + N'(1))) == '0) ||
                     ((w_inv & (w_inv + N'(1))) == '0);
  assign w_john_ph = (load_val[0] || (load_val == '0)) ? w_pop :
                     PW'(c_two_n - {1'b0, w_pop});
  assign w_load_ok = mode ? w_john_ok : w_ring_ok;
  assign w_load_ph = mode ? w_john_ph : w_idx;
  assign w_start_t = mode ? '0 : c_ring_start;
  assign w_last    = r_mode_q ? c_last_john : c_last_ring;

  always_comb begin
    w_t_nxt    = r_t;
    w_ph_nxt   = r_phase;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (clr) begin
      w_t_nxt  = w_start_t;
      w_ph_nxt = '0;
    end else if (load) begin
      if (w_load_ok) begin
        w_t_nxt  = load_val;
        w_ph_nxt = w_load_ph;
      end else begin
        w_t_nxt   = w_start_t;
        w_ph_nxt  = '0;
        w_err_nxt = 1'b1;
      end
    end else if (mode != r_mode_q) begin
      w_t_nxt  = w_start_t;
      w_ph_nxt = '0;
    end else if (en) begin
      if (!dir) begin
        w_t_nxt    = r_mode_q ? {r_t[N-2:0], ~r_t[N-1]} : {r_t[N-2:0], r_t[N-1]};
        w_wrap_nxt = (r_phase == w_last);
        w_ph_nxt   = w_wrap_nxt ? '0 : r_phase + PW'(1);
      end else begin
        w_t_nxt    = r_mode_q ? {~r_t[0], r_t[N-1:1]} : {r_t[0], r_t[N-1:1]};
        w_wrap_nxt = (r_phase == '0);
        w_ph_nxt   = w_wrap_nxt ? w_last : r_phase - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t      <= c_ring_start;
      r_phase  <= '0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_t      <= w_t_nxt;
      r_phase  <= w_ph_nxt;
      r_wrap   <= w_wrap_nxt;
      r_err    <= w_err_nxt;
      r_mode_q <= mode;
    end
  end

  assign t     = r_t;
  assign phase = r_phase;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ring_counter_n.sv
// ============================================================================
// Module   : tb_ring_counter_n
// Brief    : Directed-vector bench for ring_counter_n (N = 4) with a
//            queue-based scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_counter_n;

  logic       clk;
  logic       rst;
  logic       en, dir, mode, clr, load;
  logic [3:0] load_val;
  logic [3:0] t;
  logic [2:0] phase;
  logic       wrap, err;

  typedef struct {
    logic [3:0] t;
    logic [2:0] ph;
    logic       w;
    logic       e;
    string      nm;
  } exp_s;

  exp_s q[$];
  int   total = 0;
  int   bad   = 0;

  ring_counter_n #(.N(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .t(t), .phase(phase), .wrap(wrap), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] et, input logic [2:0] ep,
                     input logic ew, input logic ee);
    total++;
    if (t !== et || phase !== ep || wrap !== ew || err !== ee) begin
      bad++;
      $display("FAIL %s: got t=%b phase=%0d wrap=%b err=%b, want t=%b phase=%0d wrap=%b err=%b",
               nm, t, phase, wrap, err, et, ep, ew, ee);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_s e;
      e = q.pop_front();
      chk(e.nm, e.t, e.ph, e.w, e.e);
    end
  end

  task automatic step(input string nm, input logic i_en, input logic i_dir,
                      input logic i_mode, input logic i_clr, input logic i_load,
                      input logic [3:0] i_lv, input logic [3:0] et,
                      input logic [2:0] ep, input logic ew, input logic ee);
    exp_s e;
    @(negedge clk);
    en = i_en; dir = i_dir; mode = i_mode; clr = i_clr; load = i_load; load_val = i_lv;
    e.t = et; e.ph = ep; e.w = ew; e.e = ee; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b0; en = 0; dir = 0; mode = 0; clr = 0; load = 0; load_val = '0;
    #12;
    chk("reset", 4'b0001, 3'd0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Ring up, wrap on return to 0001
    step("ring_up1", 1,0,0,0,0,4'h0, 4'b0010, 3'd1, 0, 0);
    step("ring_up2", 1,0,0,0,0,4'h0, 4'b0100, 3'd2, 0, 0);
    step("ring_up3", 1,0,0,0,0,4'h0, 4'b1000, 3'd3, 0, 0);
    step("ring_wrap",1,0,0,0,0,4'h0, 4'b0001, 3'd0, 1, 0);
    step("ring_up5", 1,0,0,0,0,4'h0, 4'b0010, 3'd1, 0, 0);

    // Johnson up: mode change then full 8-state cycle
    step("j_mchg",   1,0,1,0,0,4'h0, 4'b0000, 3'd0, 0, 0);
    step("j_up1",    1,0,1,0,0,4'h0, 4'b0001, 3'd1, 0, 0);
    step("j_up2",    1,0,1,0,0,4'h0, 4'b0011, 3'd2, 0, 0);
    step("j_up3",    1,0,1,0,0,4'h0, 4'b0111, 3'd3, 0, 0);
    step("j_up4",    1,0,1,0,0,4'h0, 4'b1111, 3'd4, 0, 0);
    step("j_up5",    1,0,1,0,0,4'h0, 4'b1110, 3'd5, 0, 0);
    step("j_up6",    1,0,1,0,0,4'h0, 4'b1100, 3'd6, 0, 0);
    step("j_up7",    1,0,1,0,0,4'h0, 4'b1000, 3'd7, 0, 0);
    step("j_wrap",   1,0,1,0,0,4'h0, 4'b0000, 3'd0, 1, 0);

    // Climb to 0111 then reverse
    step("j_a1",     1,0,1,0,0,4'h0, 4'b0001, 3'd1, 0, 0);
    step("j_a2",     1,0,1,0,0,4'h0, 4'b0011, 3'd2, 0, 0);
    step("j_a3",     1,0,1,0,0,4'h0, 4'b0111, 3'd3, 0, 0);
    step("j_dn1",    1,1,1,0,0,4'h0, 4'b0011, 3'd2, 0, 0);
    step("j_dn2",    1,1,1,0,0,4'h0, 4'b0001, 3'd1, 0, 0);
    step("j_dn3",    1,1,1,0,0,4'h0, 4'b0000, 3'd0, 0, 0);
    step("j_dnwrap", 1,1,1,0,0,4'h0, 4'b1000, 3'd7, 1, 0);

    // Hold with dir toggling
    for (int i = 0; i < 5; i++)
      step("hold", 0, i[0], 1,0,0,4'h0, 4'b1000, 3'd7, 0, 0);

    // Loads
    step("rload_ok",  0,0,0,0,1,4'b0100, 4'b0100, 3'd2, 0, 0);
    step("rload_bad", 0,0,0,0,1,4'b0110, 4'b0001, 3'd0, 0, 1);
    step("err_clear", 0,0,0,0,0,4'h0,    4'b0001, 3'd0, 0, 0);
    step("rload_msb", 0,0,0,0,1,4'b1000, 4'b1000, 3'd3, 0, 0);
    step("jload_1100",0,0,1,0,1,4'b1100, 4'b1100, 3'd6, 0, 0);
    step("jload_bad", 0,0,1,0,1,4'b0101, 4'b0000, 3'd0, 0, 1);
    step("jload_1111",0,0,1,0,1,4'b1111, 4'b1111, 3'd4, 0, 0);
    step("jload_1110",0,0,1,0,1,4'b1110, 4'b1110, 3'd5, 0, 0);
    step("jload_0000",0,0,1,0,1,4'b0000, 4'b0000, 3'd0, 0, 0);

    // Ring down: mode change swallows en, then wrap 0 -> 3
    step("r_mchg",   1,1,0,0,0,4'h0, 4'b0001, 3'd0, 0, 0);
    step("r_dnwrap", 1,1,0,0,0,4'h0, 4'b1000, 3'd3, 1, 0);
    step("r_dn",     1,1,0,0,0,4'h0, 4'b0100, 3'd2, 0, 0);

    // clr beats load and en
    step("clr_all",  1,0,0,1,1,4'b0110, 4'b0001, 3'd0, 0, 0);
    step("clr_john", 1,0,1,1,0,4'h0,    4'b0000, 3'd0, 0, 0);
    step("clr_ring", 0,0,0,1,0,4'h0,    4'b0001, 3'd0, 0, 0);
    step("pre_rst1", 1,0,0,0,0,4'h0,    4'b0010, 3'd1, 0, 0);
    step("pre_rst2", 1,0,0,0,0,4'h0,    4'b0100, 3'd2, 0, 0);

    // Asynchronous reset mid-sequence
    @(negedge clk); #2;
    rst = 1'b0;
    #1 chk("rst_mid", 4'b0001, 3'd0, 1'b0, 1'b0);
    @(negedge clk); en = 0; rst = 1'b1;
    step("post_rst", 1,0,0,0,0,4'h0, 4'b0010, 3'd1, 0, 0);

    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (q.size() > 0) begin
        total++; bad++;
        $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
